load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU: consumes the ALU result as an address or a pass-through value.
//  Issues loads/stores to the data memory over a req/ready handshake. Aligns and extends load data, and builds
//  store byte strobes. Delivers one writeback beat per accepted op and flags misaligned or timed-out accesses.
// PARAMETERS
//  DATA_WIDTH       32   datapath width (`DATA_WIDTH)
//  TIMEOUT_CYCLES   16   max cycles mem_req may wait for mem_ready before access_fault
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  in_valid     in   1   op presented this cycle
//  in_ready     out  1   1 only in IDLE; op accepted when in_valid & in_ready
//  is_load      in   1   op is LB/LH/LW/LBU/LHU
//  is_store     in   1   op is SB/SH/SW (is_load & is_store never both 1)
//  funct3       in   3   width/sign select (F3 codes in rv32i_control.vh)
//  alu_result   in   32  effective address (ld/st) or result (other ops)
//  store_data   in   32  rs2 value for stores
//  rd_in        in   5   destination register
//  mem_req      out  1   memory request, held until mem_ready
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word-aligned address {alu_result[31:2],2'b00}
//  mem_wdata    out  32  store data replicated into lanes
//  mem_wstrb    out  4   byte enables, 0 on reads
//  mem_ready    in   1   memory completes the request this cycle
//  mem_rdata    in   32  read word, valid when mem_ready & ~mem_we
//  wb_valid     out  1   one-cycle writeback beat
//  wb_rd        out  5   destination register, 0 for stores/faults
//  wb_data      out  32  loaded or pass-through value
//  misaligned   out  1   one-cycle pulse with wb_valid
//  access_fault out  1   one-cycle pulse with wb_valid on timeout
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0 except in_ready=1; timeout counter=0.
//  FSM states: IDLE, MEM, DONE.
//  IDLE, accept, non-ld/st -> DONE; wb_data=alu_result; pass-through latency is 1 cycle.
//  IDLE, accept, ld/st misaligned (LH/LHU/SH with addr[0]; LW/SW with addr[1:0]!=0) -> DONE:
//    no mem_req; misaligned=1; wb_rd=0.
//  IDLE, accept, aligned ld/st -> MEM with mem_req=1; address, strobes and data are registered at accept.
//  MEM: req/we/addr/wdata/wstrb stay stable until mem_ready.
//    mem_ready in the same cycle as req is legal; minimum load latency is 2 cycles from accept to wb_valid.
//    mem_ready -> DONE; mem_req drops the next cycle.
//    Counter increments each MEM cycle without mem_ready. Count reaches TIMEOUT_CYCLES -> DONE with access_fault=1,
//    wb_rd=0; late mem_ready in IDLE is ignored.
//  DONE: wb_valid=1 for exactly one cycle -> IDLE; counter cleared.
//  Stores: wb_valid=1, wb_rd=0.
//  Store strobes: SB 4'b0001<<addr[1:0], SH 4'b0011<<addr[1:0], SW 4'b1111.
//    wdata = byte/half replicated across all lanes.
//  Loads: select lane by addr[1:0]. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through unchanged.
//  rd_in==0: ops proceed normally; wb_rd=0.
//  Reset mid-MEM: mem_req drops immediately (async); no wb_valid is produced.
// STRUCTURE
//  State encodings LSU_ST_IDLE/MEM/DONE and TIMEOUT default belong in rv32i_control.vh.
//  F3 load/store codes are reused from the same header.
//  Sub-module lsu_load_align (combinational): funct3 + addr[1:0] + rdata -> extended 32-bit value.
//  FSM, counter and store-strobe logic live in the top module.
// TESTING
//  Pass-through: alu_result=32'h0000_001E, rd=5 -> next cycle wb_valid=1, wb_data=0000001E, wb_rd=5, mem_req never 1.
//  LB sign: addr=0x103, mem_rdata=32'h80FF_FF7F after 3 wait cycles -> mem_addr=0x100, wb_data=FFFFFF80.
//  LHU: addr=0x102 -> wb_data=000080FF; LH same address -> FFFF80FF.
//  SH addr=0x206, store_data=0x1234_ABCD -> mem_wstrb=1100, mem_wdata=ABCDABCD, mem_we=1; wb_rd=0.
//  LW addr=0x101 -> misaligned=1, wb_valid=1 one cycle after accept, mem_req stays 0.
//  Timeout: mem_ready held 0 -> access_fault after 16 MEM cycles; then assert rst mid-MEM on a fresh op
//    -> mem_req=0 at once, in_ready=1.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, default
// memory timeout, RV32I funct3 width/sign codes for loads and stores, and the
// alignment rule shared by loads and stores.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_ST_IDLE = 2'd0,
    LSU_ST_MEM  = 2'd1,
    LSU_ST_DONE = 2'd2
  } lsu_state_t;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // funct3[1:0] carries the access size for both loads and stores:
  // 00 byte (never misaligned), 01 half (addr[0] must be 0), 10 word.
  function automatic logic lsu_misaligned(input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load data aligner.
// Selects the byte or halfword lane addressed by addr_lo from the memory
// read word and sign- or zero-extends it according to funct3.
// Ports:
//   funct3  - load width/sign code
//   addr_lo - low two bits of the effective address
//   rdata   - raw word returned by the data memory
//   data    - aligned and extended load value
module lsu_load_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // Halfword lanes ignore addr_lo[0]; misaligned halves never reach here.
    lane_b = 8'(rdata >> {addr_lo, 3'b000});
    lane_h = 16'(rdata >> {addr_lo[1], 4'b0000});
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
      F3_LH:   data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
      F3_LHU:  data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage following the ALU. Non-memory ops pass alu_result straight to
// writeback; loads and stores are issued to data memory over a req/ready
// handshake with a bounded wait. Every accepted op produces exactly one
// writeback beat, flagged when the access was misaligned or timed out.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   in_valid/in_ready        - op handshake (in_ready only in IDLE)
//   is_load, is_store        - op class
//   funct3                   - access width/sign
//   alu_result               - address for ld/st, result otherwise
//   store_data, rd_in        - store source value, destination register
//   mem_req/we/addr/wdata/wstrb, mem_ready, mem_rdata - data memory port
//   wb_valid, wb_rd, wb_data - one-cycle writeback beat
//   misaligned, access_fault - status pulses accompanying wb_valid
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    is_load,
  input  logic                    is_store,
  input  logic [2:0]              funct3,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [4:0]              rd_in,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [DATA_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    misaligned,
  output logic                    access_fault
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t            state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [2:0]            op_funct3;
  logic [1:0]            op_addr_lo;
  logic [4:0]            op_rd;

  logic                  is_mem_op;
  logic                  bad_align;
  logic [STRB_W-1:0]     store_strb;
  logic [DATA_WIDTH-1:0] store_lanes;
  logic [DATA_WIDTH-1:0] load_value;

  always_comb begin
    is_mem_op = is_load | is_store;
    bad_align = lsu_misaligned(funct3, alu_result[1:0]);
  end

  // Byte/half store data is replicated into every lane so the memory only
  // has to honour the strobes.
  always_comb begin
    store_strb  = '1;
    store_lanes = store_data;
    case (funct3)
      F3_SB: begin
        store_strb  = STRB_W'(1) << alu_result[1:0];
        store_lanes = {STRB_W{store_data[7:0]}};
      end
      F3_SH: begin
        store_strb  = STRB_W'(3) << alu_result[1:0];
        store_lanes = {(DATA_WIDTH/16){store_data[15:0]}};
      end
      F3_SW: begin
        store_strb  = '1;
        store_lanes = store_data;
      end
      default: ;
    endcase
  end

  lsu_load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .funct3  (op_funct3),
    .addr_lo (op_addr_lo),
    .rdata   (mem_rdata),
    .data    (load_value)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LSU_ST_IDLE;
      wait_cnt     <= '0;
      in_ready     <= 1'b1;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      misaligned   <= 1'b0;
      access_fault <= 1'b0;
      op_funct3    <= '0;
      op_addr_lo   <= '0;
      op_rd        <= '0;
    end else begin
      case (state)
        LSU_ST_IDLE: begin
          // in_ready is registered high throughout IDLE, so in_valid alone
          // marks acceptance here; mem_ready arriving now is ignored.
          if (in_valid) begin
            in_ready   <= 1'b0;
            op_funct3  <= funct3;
            op_addr_lo <= alu_result[1:0];
            op_rd      <= rd_in;
            if (!is_mem_op) begin
              state    <= LSU_ST_DONE;
              wb_valid <= 1'b1;
              wb_rd    <= rd_in;
              wb_data  <= alu_result;
            end else if (bad_align) begin
              state      <= LSU_ST_DONE;
              wb_valid   <= 1'b1;
              wb_rd      <= '0;
              wb_data    <= '0;
              misaligned <= 1'b1;
            end else begin
              state     <= LSU_ST_MEM;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {alu_result[DATA_WIDTH-1:2], 2'b00};
              mem_wdata <= is_store ? store_lanes : '0;
              mem_wstrb <= is_store ? store_strb : '0;
            end
          end
        end

        LSU_ST_MEM: begin
          if (mem_ready) begin
            state     <= LSU_ST_DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            wb_valid  <= 1'b1;
            wb_rd     <= mem_we ? '0 : op_rd;
            wb_data   <= mem_we ? '0 : load_value;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            // This is the TIMEOUT_CYCLES-th cycle spent waiting.
            state        <= LSU_ST_DONE;
            wait_cnt     <= wait_cnt + 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_wstrb    <= '0;
            wb_valid     <= 1'b1;
            wb_rd        <= '0;
            wb_data      <= '0;
            access_fault <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        LSU_ST_DONE: begin
          state        <= LSU_ST_IDLE;
          in_ready     <= 1'b1;
          wait_cnt     <= '0;
          wb_valid     <= 1'b0;
          wb_rd        <= '0;
          misaligned   <= 1'b0;
          access_fault <= 1'b0;
        end

        default: begin
          state    <= LSU_ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
